// File: rtl/lagarto_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package lagarto_loader_pkg;

  localparam int unsigned INST_W         = 32;
  localparam int unsigned BYTES_PER_INST = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } loader_state_e;

endpackage

// File: rtl/loader_word_packer.sv
// Assembles a little-endian byte stream into 32-bit words.
// word_valid_o flags that the byte accepted this cycle completes a word;
// the completed word is visible on word_o from the next cycle on.
module loader_word_packer
  import lagarto_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              flush_i,
  input  logic              byte_en_i,
  input  logic [7:0]        byte_i,
  output logic [INST_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [INST_W-1:0] word_r;
  logic [1:0]        idx_r;

  // Shift accepted bytes in from the top so byte 0 ends in the low lane after four bytes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      word_r <= {INST_W{1'b0}};
      idx_r  <= 2'd0;
    end else if (flush_i) begin
      word_r <= {INST_W{1'b0}};
      idx_r  <= 2'd0;
    end else if (byte_en_i) begin
      word_r <= {byte_i, word_r[INST_W-1:8]};
      idx_r  <= idx_r + 2'd1;
    end else begin
      word_r <= word_r;
      idx_r  <= idx_r;
    end
  end

  assign word_o       = word_r;
  assign word_valid_o = byte_en_i && (idx_r == 2'(BYTES_PER_INST - 1));

endmodule

// File: rtl/inst_mem_loader.sv
// Program loader: turns a byte stream into instruction-memory writes at
// consecutive word addresses and holds the core in reset until the image is in.
module inst_mem_loader
  import lagarto_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [15:0]       len_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              inst_we_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INST_W-1:0] instruction_o,
  output logic              core_rstn_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  // Wide enough to hold BASE_ADDR + 4*len_i without wrapping.
  localparam int unsigned EXT_W = ADDR_W + 19;

  loader_state_e     state_r, state_next_s;
  logic [15:0]       len_r, count_r;
  logic [ADDR_W-1:0] addr_r;
  logic              error_r, error_next_s;
  logic              byte_ready_r, inst_we_r, core_rstn_r, busy_r, done_r;
  logic              start_take_s, byte_accept_s, word_done_s, overflow_s;
  logic [EXT_W-1:0]  end_addr_s;
  logic [INST_W-1:0] word_s;

  assign start_take_s  = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign byte_accept_s = byte_valid_i && byte_ready_r;
  assign end_addr_s    = EXT_W'(BASE_ADDR) + (EXT_W'(len_i) << 2);
  assign overflow_s    = end_addr_s > (EXT_W'(1'b1) << ADDR_W);

  loader_word_packer u_packer (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .flush_i      (start_take_s),
    .byte_en_i    (byte_accept_s),
    .byte_i       (byte_i),
    .word_o       (word_s),
    .word_valid_o (word_done_s)
  );

  // Next-state and sticky-error decision.
  always_comb begin
    state_next_s = state_r;
    error_next_s = error_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          error_next_s = 1'b0;
          if (len_i == 16'd0) begin
            state_next_s = ST_DONE;
          end else if (overflow_s) begin
            state_next_s = ST_DONE;
            error_next_s = 1'b1;
          end else begin
            state_next_s = ST_COLLECT;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      ST_COLLECT: begin
        if (word_done_s) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_COLLECT;
        end
      end
      ST_WRITE: begin
        if ((count_r + 16'd1) == len_r) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_COLLECT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        error_next_s = 1'b0;
      end
    endcase
  end

  // State register and output flags decoded from the next state so they are registered.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r      <= ST_IDLE;
      error_r      <= 1'b0;
      byte_ready_r <= 1'b0;
      inst_we_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      core_rstn_r  <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      error_r      <= error_next_s;
      byte_ready_r <= (state_next_s == ST_COLLECT);
      inst_we_r    <= (state_next_s == ST_WRITE);
      busy_r       <= (state_next_s == ST_COLLECT) || (state_next_s == ST_WRITE);
      done_r       <= (state_next_s == ST_DONE);
      core_rstn_r  <= (state_next_s == ST_DONE) && !error_next_s;
    end
  end

  // Length latch, word counter and write address; the address advances after each write cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      len_r   <= 16'd0;
      count_r <= 16'd0;
      addr_r  <= BASE_ADDR;
    end else if (start_take_s) begin
      len_r   <= len_i;
      count_r <= 16'd0;
      addr_r  <= BASE_ADDR;
    end else if (state_r == ST_WRITE) begin
      len_r   <= len_r;
      count_r <= count_r + 16'd1;
      addr_r  <= addr_r + ADDR_W'(3'd4);
    end else begin
      len_r   <= len_r;
      count_r <= count_r;
      addr_r  <= addr_r;
    end
  end

  assign byte_ready_o  = byte_ready_r;
  assign inst_we_o     = inst_we_r;
  assign inst_addr_o   = addr_r;
  assign instruction_o = word_s;
  assign core_rstn_o   = core_rstn_r;
  assign busy_o        = busy_r;
  assign done_o        = done_r;
  assign error_o       = error_r;

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Program loader that drives the instruction-memory write port of the scalar core (write enable, 16-bit address, 32-bit instruction) from an external byte stream. It assembles little-endian bytes into 32-bit instructions and writes them to consecutive word addresses starting at a base. It holds the core/vector datapath in reset until the image is complete. It sits in the top-level datapath between the test/boot interface and the core's instruction-write inputs.

## Interface
Parameters:
- ADDR_W, 16, instruction-memory byte-address width
- BASE_ADDR, 16'h0000, byte address of the first instruction; multiple of 4

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- start_i  in  1  begin a load; sampled only in IDLE or DONE
- len_i  in  16  number of 32-bit words to load; sampled with start_i
- byte_i  in  8  stream byte
- byte_valid_i  in  1  byte_i valid
- byte_ready_o  out  1  loader accepts a byte this cycle
- inst_we_o  out  1  instruction-memory write strobe, one-cycle pulse per word
- inst_addr_o  out  ADDR_W  write byte address
- instruction_o  out  32  write data
- core_rstn_o  out  1  active-low hold for core and vector datapath
- busy_o  out  1  load in progress
- done_o  out  1  load finished; sticky until next accepted start
- error_o  out  1  length overflow; sticky until next accepted start

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: byte_ready_o=0. start_i=1 latches len_i.
  - len_i==0 -> DONE.
  - BASE_ADDR + 4*len_i > 2^ADDR_W -> DONE with error_o=1. No writes.
  - Otherwise -> COLLECT with word count 0, address BASE_ADDR, byte index 0.
- COLLECT: byte_ready_o=1. A byte is accepted when byte_valid_i & byte_ready_o.
  - Byte k of a word (k=0..3) goes to bits [8k+7:8k].
  - On the 4th accepted byte -> WRITE.
- WRITE: byte_ready_o=0. inst_we_o=1 for exactly this cycle, with instruction_o and inst_addr_o stable.
  - Next cycle: address += 4 and word count += 1.
  - If count reaches len -> DONE; otherwise -> COLLECT.
- DONE: done_o=1 and core_rstn_o=1. start_i restarts the load exactly as from IDLE: clears done_o/error_o and drives core_rstn_o=0 on the next cycle.
- start_i outside IDLE/DONE is ignored. Bytes offered while byte_ready_o=0 are not consumed.
- busy_o=1 in COLLECT and WRITE.
- core_rstn_o=0 in IDLE, COLLECT and WRITE. In DONE with error_o=1, core_rstn_o stays 0.

## Timing
- Reset values: state IDLE; byte_ready_o=0, inst_we_o=0, inst_addr_o=BASE_ADDR, instruction_o=0, core_rstn_o=0, busy_o=0, done_o=0, error_o=0.
- Every output is registered.
- The 4th byte is accepted at edge t. inst_we_o is high in cycle t+1. byte_ready_o returns high in cycle t+2.
- Minimum rate is 5 cycles per word when byte_valid_i is held high.
- Last write in cycle t: done_o=1 and core_rstn_o=1 from cycle t+1.
- start_i accepted at edge t: busy_o=1 and byte_ready_o=1 from cycle t+1.
- Asserting rstn_i mid-load aborts immediately. A partial word is discarded, no write occurs, and all outputs return to reset values. Words already written stay in memory.
- Address arithmetic is ADDR_W bits. The overflow check prevents wrap, so the last written address is at most 2^ADDR_W-4.

## Structure
- Package lagarto_loader_pkg holds:
  - state enum (IDLE, COLLECT, WRITE, DONE)
  - INST_W=32
  - BYTES_PER_INST=4
- Sub-module loader_word_packer holds the byte shift/assembly register and the 2-bit byte index. Its outputs are word_o and word_valid_o. It clears on a flush input and on reset.
- The FSM, counters, length check and output registers are in inst_mem_loader.

## Test plan
- Single word: len=1, bytes 0x13,0x00,0x00,0x00 back-to-back -> one inst_we_o pulse, addr 0x0000, data 0x00000013; done_o=1 and core_rstn_o=1 the cycle after.
- Three words with gaps: byte_valid_i toggling every other cycle, words 0x00100093, 0x00208113, 0x0000006F -> writes at 0x0000, 0x0004, 0x0008 in order; exactly 3 pulses; byte_ready_o=0 during each WRITE cycle.
- Zero and overflow: len=0 -> DONE, no write, error_o=0. With BASE_ADDR=16'hFFF8, len=3 -> error_o=1, no write, core_rstn_o stays 0.
- Reset mid-load: len=2, reset asserted after 6 bytes -> exactly one write (addr 0x0000); all outputs at reset values immediately; no second write.
- Restart: after done, start with len=1, bytes 0xEF,0xBE,0xAD,0xDE -> done_o and core_rstn_o low the next cycle; write 0xDEADBEEF at BASE_ADDR; done_o high again.
- start_i pulsed during COLLECT -> ignored; len and address are unchanged.
